// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on magnitudes, sign fix-up in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_CPU,
  input  logic             rst_CPU_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [DW-1:0] neg_2w(input logic [DW-1:0] v, input logic en);
    logic signed [DW-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             bz_q, bz_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             in_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;
  logic [DW-1:0]    prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    bz_d     = bz_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    a_d      = a_q;
    dvsr_d   = dvsr_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    in_signed = ~op[0];
    mag_a     = neg_w(opA, in_signed & opA[WIDTH-1]);
    mag_b     = neg_w(opB, in_signed & opB[WIDTH-1]);
    mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    rem_sh    = acc_q[DW-1:WIDTH-1];
    ge        = rem_sh >= {1'b0, dvsr_q};
    sub       = rem_sh[WIDTH-1:0] - dvsr_q;
    prod      = neg_2w(acc_q, neg_lo_q);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !flush) begin
          state_d  = CALC;
          cnt_d    = CNT_W'(WIDTH);
          is_div_d = op[1];
          a_d      = opA;
          bz_d     = (opB == '0);
          neg_lo_d = in_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          neg_hi_d = in_signed & opA[WIDTH-1];
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            dvsr_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            dvsr_d = mag_a;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          acc_d = {(ge ? sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_d == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        dbz_d   = 1'b0;
        if (!is_div_q) begin
          hi_d = prod[DW-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (bz_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = neg_w(acc_q[DW-1:WIDTH], neg_hi_q);
          lo_d = neg_w(acc_q[WIDTH-1:0], neg_lo_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons the operation without touching the architectural HI/LO.
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk_CPU) begin
    if (!rst_CPU_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk_CPU) begin
    is_div_q <= is_div_d;
    bz_q     <= bz_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    a_q      <= a_d;
    dvsr_q   <= dvsr_d;
    acc_q    <= acc_d;
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: 32-bit and 8-bit instances, vector table plus
// scoreboard of expected results, and hand sequences for flush/reset/back-to-back.
module tb_mips_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, flush, busy, done, dbz;
  logic [1:0]  op;
  logic [31:0] opA, opB, hi, lo;

  logic        s8_start, s8_flush, s8_busy, s8_done, s8_dbz;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_hi, s8_lo;

  mips_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_CPU(clk), .rst_CPU_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  mips_muldiv_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk_CPU(clk), .rst_CPU_n(rst_n), .start(s8_start), .op(s8_op), .opA(s8_a), .opB(s8_b),
    .flush(s8_flush), .busy(s8_busy), .done(s8_done), .hi(s8_hi), .lo(s8_lo), .div_by_zero(s8_dbz)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk_e(input logic [31:0] h, input logic [31:0] l, input logic d);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.dbz = d;
    return e;
  endfunction

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] h, input logic [31:0] l, input logic d);
    vec_t v;
    v.op = o;
    v.a  = a;
    v.b  = b;
    v.e  = mk_e(h, l, d);
    return v;
  endfunction

  // Reference built on native 64-bit arithmetic (truncating division).
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          sq = sa / sb; sr = sa % sb;
          p = sq; e.lo = p[31:0];
          p = sr; e.hi = p[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit hold, input string name);
    int   lat, bcnt, want;
    exp_t got;
    logic d;
    if (w8) begin
      s8_op = o; s8_a = a[7:0]; s8_b = b[7:0]; s8_start = 1'b1;
    end else begin
      op = o; opA = a; opB = b; start = 1'b1;
    end
    sb_q.push_back(e);
    tick;
    if (!hold) begin
      start = 1'b0; s8_start = 1'b0;
    end
    lat  = 0;
    bcnt = 0;
    d    = w8 ? s8_done : done;
    while (!d && lat < 100) begin
      if (w8 ? s8_busy : busy) bcnt++;
      if (hold) begin
        start = busy;
        op    = 2'($urandom);
        opA   = $urandom;
        opB   = $urandom;
      end
      tick;
      lat++;
      d = w8 ? s8_done : done;
    end
    start = 1'b0; s8_start = 1'b0;
    got  = sb_q.pop_front();
    want = w8 ? 9 : 33;
    if (!d) begin
      chk({name, " done"}, 64'(d), 64'd1);
    end else begin
      chk({name, " latency"}, 64'(lat), 64'(want));
      chk({name, " busy_cycles"}, 64'(bcnt), 64'(want));
      if (w8) begin
        chk({name, " hi"}, {56'b0, s8_hi}, {56'b0, got.hi[7:0]});
        chk({name, " lo"}, {56'b0, s8_lo}, {56'b0, got.lo[7:0]});
        chk({name, " dbz"}, 64'(s8_dbz), 64'(got.dbz));
      end else begin
        chk({name, " hi"}, {32'b0, hi}, {32'b0, got.hi});
        chk({name, " lo"}, {32'b0, lo}, {32'b0, got.lo});
        chk({name, " dbz"}, 64'(dbz), 64'(got.dbz));
      end
    end
    last_e = got;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[13];
    exp_t        e;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          dcnt;

    vt[0]  = mk(2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    vt[1]  = mk(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    vt[2]  = mk(2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    vt[3]  = mk(2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
    vt[4]  = mk(2'd2, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
    vt[5]  = mk(2'd1, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0);
    vt[6]  = mk(2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    vt[7]  = mk(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
    vt[8]  = mk(2'd2, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1);
    vt[9]  = mk(2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
    vt[10] = mk(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    vt[11] = mk(2'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0);
    vt[12] = mk(2'd0, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);

    // Reset with start and flush both asserted.
    rst_n = 1'b0; start = 1'b1; flush = 1'b1; op = 2'd0; opA = 32'd3; opB = 32'd4;
    s8_start = 1'b1; s8_flush = 1'b1; s8_op = 2'd0; s8_a = 8'd3; s8_b = 8'd4;
    tick;
    tick;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", {32'b0, hi}, 64'd0);
    chk("rst lo", {32'b0, lo}, 64'd0);
    chk("rst dbz", 64'(dbz), 64'd0);
    chk("rst8 busy", 64'(s8_busy), 64'd0);
    chk("rst8 hi", {56'b0, s8_hi}, 64'd0);
    chk("rst8 lo", {56'b0, s8_lo}, 64'd0);
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; s8_start = 1'b0; s8_flush = 1'b0;
    tick;
    chk("idle busy", 64'(busy), 64'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, vt[i].op, vt[i].a, vt[i].b, vt[i].e, 1'b0, $sformatf("vec%0d", i));
      tick;
      chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : ((i % 3 == 1) ? ($urandom >> 20) : $urandom);
      e  = model(ro, ra, rb);
      run_op(1'b0, ro, ra, rb, e, 1'b0, $sformatf("rnd%0d", i));
      tick;
    end

    // Start held (with changing operands) for the whole operation.
    run_op(1'b0, 2'd3, 32'd100, 32'd7, mk_e(32'd2, 32'd14, 1'b0), 1'b1, "hold");
    tick;
    chk("hold no_restart", 64'(busy), 64'd0);

    // Back-to-back: second start issued during the DONE cycle.
    run_op(1'b0, 2'd1, 32'd2, 32'd3, mk_e(32'd0, 32'd6, 1'b0), 1'b0, "b2b_first");
    run_op(1'b0, 2'd3, 32'd100, 32'd7, mk_e(32'd2, 32'd14, 1'b0), 1'b0, "b2b_second");
    tick;

    // Flush at CALC cycle 10.
    op = 2'd3; opA = 32'd100; opB = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush done", 64'(done), 64'd0);
    dcnt = 0;
    repeat (40) begin
      tick;
      if (done) dcnt++;
    end
    chk("flush no_done", 64'(dcnt), 64'd0);
    chk("flush hi", {32'b0, hi}, {32'b0, last_e.hi});
    chk("flush lo", {32'b0, lo}, {32'b0, last_e.lo});
    chk("flush dbz", 64'(dbz), 64'(last_e.dbz));

    // Flush and start together: start is dropped.
    op = 2'd1; opA = 32'd5; opB = 32'd5; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    chk("flush_start busy", 64'(busy), 64'd0);
    dcnt = 0;
    repeat (40) begin
      tick;
      if (done) dcnt++;
    end
    chk("flush_start no_done", 64'(dcnt), 64'd0);
    chk("flush_start lo", {32'b0, lo}, {32'b0, last_e.lo});
    run_op(1'b0, 2'd0, 32'hFFFFFFFD, 32'd7, mk_e(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0), 1'b0, "after_flush");
    tick;

    // Reset in the middle of CALC.
    op = 2'd1; opA = 32'd2; opB = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst hi", {32'b0, hi}, 64'd0);
    chk("midrst lo", {32'b0, lo}, 64'd0);
    chk("midrst dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      tick;
      if (done) dcnt++;
    end
    chk("midrst no_done", 64'(dcnt), 64'd0);

    // 8-bit instance.
    run_op(1'b1, 2'd0, 32'h80, 32'h80, mk_e(32'h40, 32'h00, 1'b0), 1'b0, "w8_mult");
    tick;
    run_op(1'b1, 2'd2, 32'h80, 32'hFF, mk_e(32'h00, 32'h80, 1'b0), 1'b0, "w8_div_ovf");
    tick;
    run_op(1'b1, 2'd1, 32'hFF, 32'hFF, mk_e(32'hFE, 32'h01, 1'b0), 1'b0, "w8_multu");
    tick;
    run_op(1'b1, 2'd2, 32'hF9, 32'h00, mk_e(32'hF9, 32'hFF, 1'b1), 1'b0, "w8_div0");
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
